// File: rtl/sum_tx_pkg.sv
// Shared types, constants and helpers for the sum_tx_ctrl block.
// Optional macro SUM_TX_ECHO_EN widens the frame to echo the operands.
package sum_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_HI,
    WAIT_LO,
    NEXT,
    DONE
  } state_e;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;

`ifdef SUM_TX_ECHO_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 3;
`endif

  // Upper-case hex digit for a 4-bit value.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/sum_tx_ctrl_btn_debounce.sv
// Button front end: synchronizer, level debouncer and press-pulse generator.
// Input and debounced level are active-low (1 = released).
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_q, press_d;

  // Synchronizer chain, resets to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[SYNC_STAGES-1] != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = ~stable_q;
        press_d  = stable_q;  // released -> pressed edge only
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sum_tx_ctrl.sv
// Operand latch and ASCII frame sequencer for the SumLatchUART datapath.
// Optional macro SUM_TX_ECHO_EN: 7-byte frame "A+B=SS\r" instead of "SS\r".
module sum_tx_ctrl
  import sum_tx_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BUSY_TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       save_a_n,
  input  logic       save_b_n,
  input  logic [3:0] data_input,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [4:0] sum_out,
  output logic       a_valid,
  output logic       b_valid,
  output logic       ctrl_busy,
  output logic       overrun
);

  localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic             av_q, av_d, bv_q, bv_d;
  logic [4:0]       sum_q, sum_d;
  logic [2:0]       idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       txd_q, txd_d;
  logic             press_a, press_b;

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset_n(reset_n), .btn_n_i(save_a_n), .press_o(press_a)
  );

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset_n(reset_n), .btn_n_i(save_b_n), .press_o(press_b)
  );

  // Byte i of the transmitted frame.
  function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [3:0] a,
                                            input logic [3:0] b, input logic [4:0] s);
`ifdef SUM_TX_ECHO_EN
    case (i)
      3'd0:    return hex_to_ascii(a);
      3'd1:    return ASCII_PLUS;
      3'd2:    return hex_to_ascii(b);
      3'd3:    return ASCII_EQ;
      3'd4:    return hex_to_ascii({3'b000, s[4]});
      3'd5:    return hex_to_ascii(s[3:0]);
      default: return ASCII_CR;
    endcase
`else
    a = a;
    b = b;
    case (i)
      3'd0:    return hex_to_ascii({3'b000, s[4]});
      3'd1:    return hex_to_ascii(s[3:0]);
      default: return ASCII_CR;
    endcase
`endif
  endfunction

  // Next-state, operand latching and transmit handshake.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    av_d     = av_q;
    bv_d     = bv_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    ovr_d    = ovr_q;
    txd_d    = txd_q;
    tx_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_a) begin a_d = data_input; av_d = 1'b1; end
        if (press_b) begin b_d = data_input; bv_d = 1'b1; end
        if (av_q && bv_q) state_d = LOAD;
      end
      LOAD: begin
        sum_d   = {1'b0, a_q} + {1'b0, b_q};
        idx_d   = 3'd0;
        ovr_d   = 1'b0;
        txd_d   = frame_byte(3'd0, a_q, b_q, sum_d);
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tmo_d    = '0;
          state_d  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy)               state_d = WAIT_LO;
        else if (tmo_q == TMO_LAST) state_d = NEXT;
        else                        tmo_d   = tmo_q + 1'b1;
      end
      WAIT_LO: begin
        if (!tx_busy) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          txd_d   = frame_byte(idx_d, a_q, b_q, sum_q);
          state_d = SEND;
        end
      end
      DONE: begin
        av_d    = 1'b0;
        bv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Presses during a frame are dropped but remembered.
    if (state_q != IDLE && (press_a || press_b)) ovr_d = 1'b1;
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      av_q    <= 1'b0;
      bv_q    <= 1'b0;
      sum_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      ovr_q   <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      av_q    <= av_d;
      bv_q    <= bv_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
      txd_q   <= txd_d;
    end
  end

  assign tx_data   = txd_q;
  assign sum_out   = sum_q;
  assign a_valid   = av_q;
  assign b_valid   = bv_q;
  assign ctrl_busy = (state_q != IDLE);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sum_tx_ctrl.sv
// Directed bench for sum_tx_ctrl with a simple UART busy model.
module tb_sum_tx_ctrl;
  import sum_tx_pkg::*;

  localparam int DEB = 4;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       save_a_n = 1'b1;
  logic       save_b_n = 1'b1;
  logic [3:0] data_input = 4'h0;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] sum_out;
  logic       a_valid, b_valid, ctrl_busy, overrun;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sum_tx_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .data_input(data_input), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .sum_out(sum_out), .a_valid(a_valid), .b_valid(b_valid), .ctrl_busy(ctrl_busy),
    .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART model: busy rises the cycle after tx_start and stays up 10 cycles.
  logic [7:0] got_bytes [0:63];
  int  n_starts = 0, busy_total = 0, busy_cnt = 0;
  bit  launch = 0, uart_en = 1, uart_kill = 0, prev_start = 0, st_s = 0;

  always @(negedge clk) begin
    st_s = tx_start;
    if (ctrl_busy) busy_total++;
    if (st_s) begin
      chk("start_while_busy", {31'd0, tx_busy}, 0);
      chk("start_back_to_back", {31'd0, prev_start}, 0);
      got_bytes[n_starts % 64] = tx_data;
      n_starts++;
    end
    prev_start = st_s;
    if (uart_kill) begin
      tx_busy = 1'b0; busy_cnt = 0; launch = 0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (launch) begin tx_busy = 1'b1; busy_cnt = 10; launch = 0; end
      if (st_s && uart_en) launch = 1;
    end
  end

  task automatic press(input bit which_b, input logic [3:0] val, input int hold);
    @(negedge clk);
    data_input = val;
    if (which_b) save_b_n = 1'b0; else save_a_n = 1'b0;
    repeat (hold) @(negedge clk);
    save_a_n = 1'b1;
    save_b_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_frame(input string tag);
    int t = 0;
    bit saw;
    while (!ctrl_busy && t < 100) begin @(negedge clk); t++; end
    saw = ctrl_busy;
    while (ctrl_busy && t < 4000) begin @(negedge clk); t++; end
    chk({tag, "_frame_end"}, {31'd0, saw && !ctrl_busy}, 1);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [4:0] s,
                             input logic [55:0] exp);
    chk({tag, "_sum"}, {27'd0, sum_out}, {27'd0, s});
    chk({tag, "_nstart"}, n_starts - base, FRAME_LEN);
    for (int i = 0; i < FRAME_LEN; i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got_bytes[(base + i) % 64]},
          {24'd0, exp[55-8*i -: 8]});
    chk({tag, "_valids_clr"}, {30'd0, a_valid, b_valid}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, bt, t;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {14'd0, tx_start, tx_data, sum_out, a_valid, b_valid, ctrl_busy, overrun}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {31'd0, ctrl_busy}, 0);

    // 9 + 7 = 0x10
    base = n_starts;
    press(0, 4'h9, DEB + 2);
    chk("a_latched", {29'd0, a_valid, b_valid, ctrl_busy}, 32'b100);
    press(1, 4'h7, DEB + 2);
    wait_frame("f97");
`ifdef SUM_TX_ECHO_EN
    check_frame("f97", base, 5'h10, {8'h39, 8'h2B, 8'h37, 8'h3D, 8'h31, 8'h30, 8'h0D});
`else
    check_frame("f97", base, 5'h10, {8'h31, 8'h30, 8'h0D, 32'h0});
`endif

    // F + F = 0x1E, letters in the hex digit
    base = n_starts;
    press(0, 4'hF, DEB + 2);
    press(1, 4'hF, DEB + 2);
    wait_frame("fFF");
`ifdef SUM_TX_ECHO_EN
    check_frame("fFF", base, 5'h1E, {8'h46, 8'h2B, 8'h46, 8'h3D, 8'h31, 8'h45, 8'h0D});
`else
    check_frame("fFF", base, 5'h1E, {8'h31, 8'h45, 8'h0D, 32'h0});
`endif

    // Short glitch is rejected, long press latches
    press(0, 4'h2, DEB - 1);
    repeat (10) @(negedge clk);
    chk("glitch_no_latch", {30'd0, a_valid, ctrl_busy}, 0);
    press(0, 4'h2, DEB + 2);
    chk("long_press_latch", {31'd0, a_valid}, 1);

    // tx_busy never rises: every byte advances by timeout
    uart_en = 0;
    base = n_starts;
    bt = busy_total;
    press(1, 4'h3, DEB + 2);
    wait_frame("ftmo");
`ifdef SUM_TX_ECHO_EN
    check_frame("ftmo", base, 5'h05, {8'h32, 8'h2B, 8'h33, 8'h3D, 8'h30, 8'h35, 8'h0D});
`else
    check_frame("ftmo", base, 5'h05, {8'h30, 8'h35, 8'h0D, 32'h0});
`endif
    chk("tmo_busy_cycles", busy_total - bt, FRAME_LEN * (TMO + 2) + 2);
    uart_en = 1;

    // Press during the second byte sets overrun and is ignored
    base = n_starts;
    press(0, 4'h1, DEB + 2);
    press(1, 4'h2, DEB + 2);
    t = 0;
    while (n_starts < base + 2 && t < 500) begin @(negedge clk); t++; end
    press(0, 4'hC, DEB + 2);
    chk("ovr_midframe", {30'd0, overrun, ctrl_busy}, 32'b11);
    wait_frame("fovr");
`ifdef SUM_TX_ECHO_EN
    check_frame("fovr", base, 5'h03, {8'h31, 8'h2B, 8'h32, 8'h3D, 8'h30, 8'h33, 8'h0D});
`else
    check_frame("fovr", base, 5'h03, {8'h30, 8'h33, 8'h0D, 32'h0});
`endif
    chk("ovr_sticky", {31'd0, overrun}, 1);
    base = n_starts;
    press(0, 4'h5, DEB + 2);
    chk("ovr_held_in_idle", {31'd0, overrun}, 1);
    press(1, 4'h5, DEB + 2);
    wait_frame("f55");
`ifdef SUM_TX_ECHO_EN
    check_frame("f55", base, 5'h0A, {8'h35, 8'h2B, 8'h35, 8'h3D, 8'h30, 8'h41, 8'h0D});
`else
    check_frame("f55", base, 5'h0A, {8'h30, 8'h41, 8'h0D, 32'h0});
`endif
    chk("ovr_cleared_by_load", {31'd0, overrun}, 0);

    // Reset during WAIT_LO of the first byte
    base = n_starts;
    press(0, 4'h3, DEB + 2);
    press(1, 4'h4, DEB + 2);
    t = 0;
    while (!(n_starts == base + 1 && tx_busy) && t < 500) begin @(negedge clk); t++; end
    chk("rst_reach_byte1", {31'd0, t < 500}, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_outputs",
           {14'd0, tx_start, tx_data, sum_out, a_valid, b_valid, ctrl_busy, overrun}, 0);
    uart_kill = 1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    uart_kill = 0;
    repeat (30) @(negedge clk);
    chk("rst_no_start", n_starts - base, 1);
    chk("rst_operands_clr", {29'd0, a_valid, b_valid, ctrl_busy}, 0);
    base = n_starts;
    press(0, 4'h6, DEB + 2);
    repeat (30) @(negedge clk);
    chk("rst_a_only_no_start", n_starts - base, 0);
    chk("rst_a_relatched", {30'd0, a_valid, b_valid}, 32'b10);
    press(1, 4'h8, DEB + 2);
    wait_frame("f68");
`ifdef SUM_TX_ECHO_EN
    check_frame("f68", base, 5'h0E, {8'h36, 8'h2B, 8'h38, 8'h3D, 8'h30, 8'h45, 8'h0D});
`else
    check_frame("f68", base, 5'h0E, {8'h30, 8'h45, 8'h0D, 32'h0});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
